full_adder_bist: RTL
====================

# full_adder_bist

Built-in self-test controller for the single-bit full adder. It sweeps all eight input combinations into the adder, samples sum and carry-out after a programmable settle time, and compares each result against a golden model. It reports pass/fail, a saturating error count, and the first failing vector. It sits beside the full_adder instance: it drives A/B/Cin and consumes S/Co, in place of a simulation-only stimulus bench.

## Interface
Parameters:
- SETTLE, default 1: cycles a vector is held before sampling; legal range is 1 or more.
- PASSES, default 1: number of full 8-vector sweeps per run; legal range is 1 or more.
- ERR_W, default 4: width of the error counter.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  run request; sampled in IDLE or DONE only.
- dut_A  out  1  adder operand A, registered.
- dut_B  out  1  adder operand B, registered.
- dut_Cin  out  1  adder carry-in, registered.
- dut_S  in  1  adder sum under test.
- dut_Co  in  1  adder carry-out under test.
- busy  out  1  run in progress.
- done  out  1  run complete; a level held until the next run or reset.
- pass  out  1  valid when done=1; 1 when err_count is 0.
- err_count  out  ERR_W  mismatches this run; saturates at 2^ERR_W-1.
- first_fail_valid  out  1  at least one mismatch this run.
- first_fail_vec  out  3  {A,B,Cin} of the first mismatch.

## Operation
- States:
  - IDLE: start=1 → DRIVE.
  - DRIVE: held for SETTLE cycles, then → CHECK.
  - CHECK: one cycle; if the vector and pass counters are both at their last value → DONE, else the vector index advances → DRIVE.
  - DONE: start=1 → DRIVE (new run); otherwise stays in DONE.
- Vector index i runs from 0 to 7, giving dut_A=i[2], dut_B=i[1], dut_Cin=i[0]. Index 7 wraps to 0 and increments the pass counter. The run ends after pass PASSES-1, vector 7.
- Golden model: exp_S = A^B^Cin; exp_Co = (A&B)|(A&Cin)|(B&Cin).
- CHECK compares dut_S/dut_Co with the golden values for the currently driven vector. On mismatch:
  - err_count increments, unless it is already saturated.
  - If first_fail_valid=0, first_fail_vec takes the vector value and first_fail_valid is set to 1.
- On entry to DRIVE from IDLE or DONE: err_count, first_fail_valid, first_fail_vec, done and pass clear; the vector and pass counters clear.
- start while busy=1 is ignored.
- Operands stay at their current value throughout CHECK. They change only on the CHECK→DRIVE edge.
- In DONE, the operands hold the last vector (1,1,1).

## Timing
- Reset values: all outputs are 0 and the state is IDLE. Reset asserted mid-run aborts on the next edge, with no partial results kept.
- Start latency: start high at edge t puts the FSM in DRIVE, busy=1 and vector 0 on the operand outputs after edge t.
- Per vector: SETTLE+1 cycles (SETTLE in DRIVE plus 1 in CHECK). dut_S/dut_Co are sampled at the edge that ends CHECK, SETTLE+1 cycles after the vector appeared.
- The DUT must be settled within SETTLE cycles of the operands changing. The full_adder is combinational, so SETTLE=1 is sufficient.
- Run length: 8·PASSES·(SETTLE+1) cycles from the first DRIVE cycle. busy falls and done/pass rise on the same edge.
- start=1 in the same cycle as the final CHECK is ignored, because busy is still 1.

## Structure
- Package full_adder_bist_pkg contains:
  - the FSM state enum (IDLE, DRIVE, CHECK, DONE);
  - the constant NUM_VECTORS = 8;
  - a function returning {exp_Co, exp_S} from {A,B,Cin}.
- full_adder_bist is a single module with no sub-modules. The top-level test wrapper instantiates it alongside full_adder.

## Test plan
- Good adder, SETTLE=1, PASSES=1, start pulse → busy for 16 cycles, then done=1, pass=1, err_count=0, first_fail_valid=0. Operands step through 000…111, each held 2 cycles.
- dut_Co stuck-at-0 → done with pass=0, err_count=4 (vectors 011, 101, 110, 111), first_fail_vec=3'b011.
- dut_S inverted, ERR_W=2, PASSES=2 → 16 mismatches, err_count saturates at 3, first_fail_vec=3'b000.
- SETTLE=3, PASSES=2, good adder → done exactly 64 cycles after the first DRIVE cycle. start pulses during busy leave the timing unchanged.
- rst_n=0 for one cycle during vector 4, then start → all outputs 0 after the reset edge. The new run begins at vector 000 with clean counters.
- From DONE with pass=0, apply start with a good adder → results clear on entry to DRIVE, and the run ends with pass=1.

Source files
------------

// File: rtl/full_adder_bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : full_adder_bist_pkg
//  Purpose : Shared types and helpers for the full-adder BIST controller:
//            the controller state encoding, the vector count and the golden
//            full-adder model.
//  Revision: 1.0  initial release
// ============================================================================
package full_adder_bist_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int NUM_VECTORS = 8;

   // Golden full adder: input {A,B,Cin}, returns {Co,S}.
   function automatic logic [1:0] golden(input logic [2:0] v);
      logic a, b, c;
      a = v[2];
      b = v[1];
      c = v[0];
      return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
   endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder_bist.sv
`default_nettype none
// ============================================================================
//  Module  : full_adder_bist
//  Purpose : Built-in self-test controller for a single-bit full adder.
//            Sweeps {A,B,Cin} through 0..7 for PASSES sweeps, holds each
//            vector SETTLE cycles, samples S/Co in a one-cycle CHECK state and
//            compares against the golden model.
//  Ports   :
//    clk              in   clock, rising edge
//    rst_n            in   synchronous active-low reset
//    start            in   run request (honoured in IDLE/DONE only)
//    dut_A/B/Cin      out  registered adder operands
//    dut_S/dut_Co     in   adder results under test
//    busy             out  run in progress
//    done             out  run complete (level)
//    pass             out  run had no mismatches (valid with done)
//    err_count        out  saturating mismatch count
//    first_fail_valid out  at least one mismatch seen
//    first_fail_vec   out  {A,B,Cin} of the first mismatch
//  Revision: 1.0  initial release
// ============================================================================
module full_adder_bist
   import full_adder_bist_pkg::*;
#(
   parameter int SETTLE = 1,
   parameter int PASSES = 1,
   parameter int ERR_W  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             dut_A,
   output logic             dut_B,
   output logic             dut_Cin,
   input  logic             dut_S,
   input  logic             dut_Co,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic             first_fail_valid,
   output logic [2:0]       first_fail_vec
);

   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

   localparam logic [SW-1:0]    c_SETTLE_LAST = SW'(SETTLE - 1);
   localparam logic [PW-1:0]    c_PASS_LAST   = PW'(PASSES - 1);
   localparam logic [2:0]       c_VEC_LAST    = 3'(NUM_VECTORS - 1);
   localparam logic [ERR_W-1:0] c_ERR_MAX     = '1;

   state_t           r_state;
   state_t           w_next;
   logic [2:0]       r_vec;
   logic [PW-1:0]    r_pass_cnt;
   logic [SW-1:0]    r_settle_cnt;
   logic [ERR_W-1:0] r_err;
   logic             r_ffv;
   logic [2:0]       r_ffvec;
   logic             r_done;
   logic             r_pass;

   logic             w_load_run;
   logic             w_check;
   logic             w_last;
   logic             w_mismatch;

   assign w_last     = (r_vec == c_VEC_LAST) && (r_pass_cnt == c_PASS_LAST);
   assign w_mismatch = ({dut_Co, dut_S} != golden(r_vec));

   // ---------------------------------------------------------------- next state
   always_comb begin
      w_next     = r_state;
      w_load_run = 1'b0;
      w_check    = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_next     = DRIVE;
               w_load_run = 1'b1;
            end
         end
         DRIVE: begin
            if (r_settle_cnt == c_SETTLE_LAST) begin
               w_next = CHECK;
            end
         end
         CHECK: begin
            w_check = 1'b1;
            w_next  = w_last ? DONE : DRIVE;
         end
         default: w_next = IDLE;
      endcase
   end

   // ---------------------------------------------------------- state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ------------------------------------------------------------ datapath regs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vec        <= '0;
         r_pass_cnt   <= '0;
         r_settle_cnt <= '0;
         r_err        <= '0;
         r_ffv        <= 1'b0;
         r_ffvec      <= '0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
      end else if (w_load_run) begin
         r_vec        <= '0;
         r_pass_cnt   <= '0;
         r_settle_cnt <= '0;
         r_err        <= '0;
         r_ffv        <= 1'b0;
         r_ffvec      <= '0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
      end else begin
         if (r_state == DRIVE) begin
            r_settle_cnt <= (r_settle_cnt == c_SETTLE_LAST) ? '0 : r_settle_cnt + 1'b1;
         end
         if (w_check) begin
            if (w_mismatch) begin
               if (r_err != c_ERR_MAX) begin
                  r_err <= r_err + 1'b1;
               end
               if (!r_ffv) begin
                  r_ffv   <= 1'b1;
                  r_ffvec <= r_vec;
               end
            end
            if (w_last) begin
               // Operands stay on the last vector; the verdict includes this
               // final comparison, so it cannot rely on r_err alone.
               r_done <= 1'b1;
               r_pass <= (r_err == '0) && !w_mismatch;
            end else begin
               r_vec <= r_vec + 1'b1;
               if (r_vec == c_VEC_LAST) begin
                  r_pass_cnt <= r_pass_cnt + 1'b1;
               end
            end
         end
      end
   end

   assign busy             = (r_state == DRIVE) || (r_state == CHECK);
   assign done             = r_done;
   assign pass             = r_pass;
   assign err_count        = r_err;
   assign first_fail_valid = r_ffv;
   assign first_fail_vec   = r_ffvec;
   assign dut_A            = r_vec[2];
   assign dut_B            = r_vec[1];
   assign dut_Cin          = r_vec[0];

endmodule
`default_nettype wire
